fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 20-bit MIPS core, directly upstream of the decode/control stage. Holds the PC, drives a synchronous-read instruction memory (one-cycle read latency), and presents one 20-bit instruction per cycle on an IF/ID register whose opcode field `if_instr[0:3]` feeds the control unit. It absorbs decode stalls with a one-entry skid buffer and accepts PC redirects from branch, jump and jmem resolution.

## Interface
- `PC_W`, 20: PC and instruction-memory word-address width. The PC is word-addressed and increments by 1.
- `RESET_PC`, 0: first fetch address after reset.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low. It has priority over every other input.
- `redirect_en`  in  1: flush the stage and load the PC with `redirect_pc`.
- `redirect_pc`  in  PC_W: redirect target.
- `id_stall`  in  1: decode cannot accept. Holds the IF/ID register while `if_valid`=1.
- `imem_en`  out  1: read enable. The address is sampled at the clock edge.
- `imem_addr`  out  PC_W: read address (the current PC).
- `imem_rdata`  in  [0:19]: data for the address presented in the previous enabled cycle. It is valid only in the cycle after `imem_en`=1.
- `if_valid`  out  1: IF/ID register holds a real instruction.
- `if_instr`  out  [0:19]: instruction. Bit 0 is the MSB and `[0:3]` is the opcode.
- `if_pc`  out  PC_W: address of `if_instr`.

## Operation
- **State machine:** IDLE → RUN.
  - IDLE is forced by reset and lasts one cycle after `rst_n` goes high.
  - RUN is held until the next reset.
- **Internal state:**
  - `pc_q`.
  - `inflight_q`: a read was issued last cycle.
  - `inflight_pc_q`.
  - Skid buffer: `skid_valid`, `skid_instr`, `skid_pc`.
- **Issue condition:** `imem_en` = RUN && !redirect_en && !skid_valid && !(if_valid && id_stall && inflight_q).
  - On issue: `imem_addr`=`pc_q`, then `pc_q`←`pc_q`+1 (mod 2^PC_W) and `inflight_q`←1 with `inflight_pc_q`←`pc_q`.
  - With no issue: `inflight_q`←0.
- **The IF/ID register is free** when `!if_valid || !id_stall`.
- **Return handling** (`inflight_q`=1, data = `imem_rdata`):
  - Register free, skid empty: IF/ID ← data.
  - Register free, skid full: IF/ID ← skid, and skid ← data.
  - Register not free: skid ← data. The issue condition guarantees the skid is empty in this case.
- **Register free with no return:**
  - Skid full: IF/ID ← skid, and skid empties.
  - Skid empty: `if_valid`←0.
- **Stall on a bubble:** `id_stall` has no effect while `if_valid`=0.
- **Redirect** (priority over stall and return):
  - `if_valid`←0, `skid_valid`←0, `inflight_q`←0, `pc_q`←`redirect_pc`.
  - Data returning in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins.
- **Bubble value:** `if_instr`=20'h00000. Opcode 0000 decodes as R-type, so decode gates `regwrite`/`memwrite` with `if_valid`.
- **Reset values:**
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `imem_en`=0, `imem_addr`=`RESET_PC`.
  - `pc_q`=`RESET_PC`, `skid_valid`=0, `inflight_q`=0, state=IDLE.
- **Reset mid-operation:** all of the above takes effect on the next edge, regardless of `redirect_en`, `id_stall` or data in flight.

## Timing
- Edges are numbered from the first rising edge with `rst_n`=1 (E1).
  - After E1: RUN, and `imem_en`=1 with `imem_addr`=`RESET_PC`.
  - After E3: `if_valid`=1 and `if_pc`=`RESET_PC`.
  - Steady-state throughput is one instruction per cycle.
- **Stall:** while `if_valid` && `id_stall`, `if_instr` and `if_pc` are stable. At most one further instruction is captured into the skid buffer, after which issue stops.
  - Release: the skid contents appear on the edge where `id_stall`=0 is sampled.
  - No gap and no duplicate in the `if_pc` sequence.
- **Redirect sampled at edge R:**
  - `imem_en`=0 in the redirect cycle.
  - Fetch of the target is issued in cycle R+1.
  - `if_valid`=1 with `if_pc`=target after edge R+2.
- **PC arithmetic:** wraps modulo 2^PC_W with no flag.

## Test plan
- **Reset and straight-line fetch:** reset, `RESET_PC`=0, memory word i = {4'b0000, i[15:0]}, no stall → `if_valid` rises after E3; `if_pc` runs 0,1,2,3… one per cycle and `if_instr` matches each address.
- **Stall absorption:** assert `id_stall` for 3 cycles while `if_pc`=5 → `if_instr` holds word 5, `imem_en` drops once the skid holds 6; after release `if_pc` runs 6,7,8 consecutively with no repeat or gap.
- **Redirect while stalled with the skid full:** `redirect_en`=1, `redirect_pc`=20'h00040 → `if_valid`=0 after that edge; two edges later `if_pc`=20'h00040; words 6 and 7 are never presented.
- **Back-to-back redirects:** targets 20'h00100 then 20'h00200 in consecutive cycles → only 0x200 and its successors appear; 0x100 is never presented.
- **PC wrap:** `RESET_PC`=20'hFFFFF → `if_pc` sequence is 0xFFFFF, 0x00000, 0x00001.
- **Reset mid-stream:** `rst_n`=0 while streaming, with `redirect_en`=1 in the same cycle → after the edge `if_valid`=0, `imem_en`=0 and `if_instr`=0; after release, fetch restarts from `RESET_PC` with the E3 latency.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, synchronous-read imem interface, IF/ID register
// with a one-entry skid buffer to absorb decode stalls, and PC redirect.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | first cycle out of reset, no fetch issued
// ST_RUN  | fetching; held until the next reset
module fetch_stage #(
  parameter int              PC_W     = 20,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [0:19]     imem_rdata,
  output logic            if_valid,
  output logic [0:19]     if_instr,
  output logic [PC_W-1:0] if_pc
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [0:19]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [0:19]     if_instr_q, if_instr_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic            reg_free;
  logic            issue;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;

    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      default: state_d = state_q;
    endcase

    reg_free = !if_valid_q || !id_stall;
    // A stalled register with data returning fills the skid, so stop issuing.
    issue    = (state_q == ST_RUN) && !redirect_en && !skid_valid_q &&
               !(if_valid_q && id_stall && inflight_q);

    if (redirect_en) begin
      pc_d         = redirect_pc;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
      if_valid_d   = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d          = pc_q + PC_W'(1);
        inflight_pc_d = pc_q;
      end
      if (inflight_q) begin
        if (!reg_free) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end else if (skid_valid_q) begin
          if_valid_d   = 1'b1;
          if_instr_d   = skid_instr_q;
          if_pc_d      = skid_pc_q;
          skid_instr_d = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end else begin
          if_valid_d = 1'b1;
          if_instr_d = imem_rdata;
          if_pc_d    = inflight_pc_q;
        end
      end else if (reg_free) begin
        if (skid_valid_q) begin
          if_valid_d   = 1'b1;
          if_instr_d   = skid_instr_q;
          if_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
        end else begin
          if_valid_d = 1'b0;
        end
      end
    end

    // Bubbles carry an all-zero word; decode gates side effects with if_valid.
    if (!if_valid_d) begin
      if_instr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
    end
  end

  assign imem_en   = issue && rst_n;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/stall/redirect/wrap/reset scenarios
// plus a randomized stall/redirect run against an instruction-stream model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        redirect_en;
  logic [19:0] redirect_pc;
  logic        id_stall;

  logic        imem_en, w_imem_en;
  logic [19:0] imem_addr, w_imem_addr;
  logic [0:19] imem_rdata, w_imem_rdata;
  logic        if_valid, w_if_valid;
  logic [0:19] if_instr, w_if_instr;
  logic [19:0] if_pc, w_if_pc;

  int total;
  int passed;

  fetch_stage #(.PC_W(20), .RESET_PC(20'h00000)) u_dut (
    .clk(clk), .rst_n(rst_n), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  fetch_stage #(.PC_W(20), .RESET_PC(20'hFFFFF)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [0:19] word(input logic [19:0] a);
    return {4'b0000, a[15:0]};
  endfunction

  // Synchronous-read memory; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    imem_rdata   <= imem_en   ? word(imem_addr)   : 20'($urandom);
    w_imem_rdata <= w_imem_en ? word(w_imem_addr) : 20'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    id_stall    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    id_stall    = 1'b0;
    tick();
    tick();
    total++;
    if ({if_valid, if_instr, if_pc, imem_en, imem_addr} !== {1'b0, 20'h0, 20'h0, 1'b0, 20'h0})
      $display("FAIL reset_values got v=%0b instr=%h pc=%h en=%0b addr=%h want all zero",
               if_valid, if_instr, if_pc, imem_en, imem_addr);
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if ({if_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 20'h0})
      $display("FAIL reset_e1 got v=%0b en=%0b addr=%h want v=0 en=1 addr=0", if_valid, imem_en, imem_addr);
    else passed++;
    tick();
    total++;
    if (if_valid !== 1'b0) $display("FAIL reset_e2 got v=%0b want 0", if_valid);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      else tick();
      total++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 20'(i), word(20'(i))})
        $display("FAIL straight_line got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 if_valid, if_pc, if_instr, 20'(i), word(20'(i)));
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [19:0] exp;
    do_reset();
    repeat (8) tick();
    total++;
    if (if_pc !== 20'h5) $display("FAIL stall_setup got pc=%h want 5", if_pc);
    else passed++;
    id_stall = 1'b1;
    #1;
    total++;
    if (imem_en !== 1'b0) $display("FAIL stall_issue_block got en=%0b want 0", imem_en);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({if_valid, if_pc, if_instr, imem_en} !== {1'b1, 20'h5, word(20'h5), 1'b0})
        $display("FAIL stall_hold got v=%0b pc=%h instr=%h en=%0b want v=1 pc=5 instr=%h en=0",
                 if_valid, if_pc, if_instr, imem_en, word(20'h5));
      else passed++;
    end
    id_stall = 1'b0;
    exp = 20'h6;
    for (int c = 0; c < 12 && exp < 20'h9; c++) begin
      tick();
      if (if_valid) begin
        total++;
        if ({if_pc, if_instr} !== {exp, word(exp)})
          $display("FAIL stall_release got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, exp, word(exp));
        else passed++;
        exp++;
      end
    end
    total++;
    if (exp !== 20'h9) $display("FAIL stall_release_timeout got next=%h want 9", exp);
    else passed++;
  endtask

  task automatic test_redirect_stalled();
    do_reset();
    repeat (8) tick();
    id_stall = 1'b1;
    tick();
    redirect_en = 1'b1;
    redirect_pc = 20'h00040;
    #1;
    total++;
    if (imem_en !== 1'b0) $display("FAIL redir_cycle_en got en=%0b want 0", imem_en);
    else passed++;
    tick();
    redirect_en = 1'b0;
    id_stall    = 1'b0;
    #1;
    total++;
    if ({if_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 20'h00040})
      $display("FAIL redir_r got v=%0b en=%0b addr=%h want v=0 en=1 addr=00040", if_valid, imem_en, imem_addr);
    else passed++;
    tick();
    total++;
    if (if_valid !== 1'b0) $display("FAIL redir_r1 got v=%0b want 0", if_valid);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 20'h40 + 20'(k), word(20'h40 + 20'(k))})
        $display("FAIL redir_stream got v=%0b pc=%h instr=%h want v=1 pc=%h",
                 if_valid, if_pc, if_instr, 20'h40 + 20'(k));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (5) tick();
    redirect_en = 1'b1;
    redirect_pc = 20'h00100;
    tick();
    total++;
    if (if_valid !== 1'b0) $display("FAIL b2b_r1 got v=%0b want 0", if_valid);
    else passed++;
    redirect_pc = 20'h00200;
    tick();
    redirect_en = 1'b0;
    total++;
    if (if_valid !== 1'b0) $display("FAIL b2b_r2 got v=%0b want 0", if_valid);
    else passed++;
    tick();
    total++;
    if (if_valid !== 1'b0) $display("FAIL b2b_r2p1 got v=%0b pc=%h want v=0", if_valid, if_pc);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 20'h200 + 20'(k), word(20'h200 + 20'(k))})
        $display("FAIL b2b_stream got v=%0b pc=%h instr=%h want v=1 pc=%h",
                 if_valid, if_pc, if_instr, 20'h200 + 20'(k));
      else passed++;
    end
  endtask

  task automatic test_pc_wrap();
    logic [19:0] exp;
    do_reset();
    tick();
    tick();
    exp = 20'hFFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({w_if_valid, w_if_pc, w_if_instr} !== {1'b1, exp, word(exp)})
        $display("FAIL pc_wrap got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 w_if_valid, w_if_pc, w_if_instr, exp, word(exp));
      else passed++;
      exp = exp + 20'h1;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    repeat (7) tick();
    rst_n       = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 20'($urandom);
    id_stall    = 1'b1;
    tick();
    total++;
    if ({if_valid, if_instr, if_pc, imem_en, imem_addr} !== {1'b0, 20'h0, 20'h0, 1'b0, 20'h0})
      $display("FAIL midreset_values got v=%0b instr=%h pc=%h en=%0b addr=%h want all zero",
               if_valid, if_instr, if_pc, imem_en, imem_addr);
    else passed++;
    rst_n       = 1'b1;
    redirect_en = 1'b0;
    id_stall    = 1'b0;
    tick();
    total++;
    if ({if_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 20'h0})
      $display("FAIL midreset_e1 got v=%0b en=%0b addr=%h want v=0 en=1 addr=0", if_valid, imem_en, imem_addr);
    else passed++;
    tick();
    total++;
    if (if_valid !== 1'b0) $display("FAIL midreset_e2 got v=%0b want 0", if_valid);
    else passed++;
    tick();
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 20'h0, word(20'h0)})
      $display("FAIL midreset_e3 got v=%0b pc=%h instr=%h want v=1 pc=0", if_valid, if_pc, if_instr);
    else passed++;
  endtask

  // Model: presented instructions form a contiguous address stream that
  // restarts at each redirect target; a stalled instruction stays put.
  task automatic test_random();
    logic [19:0] exp_next, cur_pc, target;
    logic        prev_hold, prev_redir, stall, redir;
    int          presented;
    do_reset();
    repeat (3) tick();
    exp_next   = 20'h0;
    cur_pc     = 20'h0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    presented  = 0;
    for (int n = 0; n < 400; n++) begin
      total++;
      if (prev_redir) begin
        if (if_valid !== 1'b0) $display("FAIL rand_redirect_flush got v=%0b want 0", if_valid);
        else passed++;
      end else if (prev_hold) begin
        if ({if_valid, if_pc, if_instr} !== {1'b1, cur_pc, word(cur_pc)})
          $display("FAIL rand_hold got v=%0b pc=%h instr=%h want v=1 pc=%h", if_valid, if_pc, if_instr, cur_pc);
        else passed++;
      end else if (if_valid) begin
        cur_pc   = exp_next;
        exp_next = exp_next + 20'h1;
        presented++;
        if ({if_pc, if_instr} !== {cur_pc, word(cur_pc)})
          $display("FAIL rand_stream got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, cur_pc, word(cur_pc));
        else passed++;
      end else begin
        if (if_instr !== 20'h0) $display("FAIL rand_bubble got instr=%h want 0", if_instr);
        else passed++;
      end
      stall      = ($urandom_range(9) < 3);
      redir      = ($urandom_range(19) == 0);
      target     = 20'($urandom);
      prev_hold  = if_valid && stall && !redir;
      prev_redir = redir;
      if (redir) exp_next = target;
      id_stall    = stall;
      redirect_en = redir;
      redirect_pc = target;
      tick();
    end
    id_stall    = 1'b0;
    redirect_en = 1'b0;
    total++;
    if (presented < 100) $display("FAIL rand_throughput got %0d presented want >= 100", presented);
    else passed++;
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    id_stall    = 1'b0;
    total       = 0;
    passed      = 0;
    test_reset();
    test_stall();
    test_redirect_stalled();
    test_back_to_back();
    test_pc_wrap();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
